// File: rtl/kilit_denetleyici.sv
// Sequencer in front of the combinational kilit_acici checker: dial pulses -> step counts, query, attempts, lockout.
// Latency: onay at edge n -> sorgu_gecerli in cycle n+1, acik from cycle n+2; every output is registered.
// Backpressure: none; pulses are consumed or dropped each cycle according to state and input priority.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   sag_darbe, sol_darbe      one dial step per high cycle (right / left)
//   onay, iptal               submit the sequence / abandon entry or relock
//   kilit_acik                checker verdict for the current sag_adim/sol_adim
//   sag_adim, sol_adim        step counts presented to the checker
//   sorgu_gecerli             high during the single query cycle
//   acik, kilitli             lock open / lockout active
//   kalan_hak                 attempts remaining
module kilit_denetleyici #(
    parameter int DENEME_HAKKI     = 3,
    parameter int KILITLEME_SURESI = 16,
    parameter int ZAMAN_ASIMI      = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sag_darbe,
    input  logic       sol_darbe,
    input  logic       onay,
    input  logic       iptal,
    input  logic       kilit_acik,
    output logic [2:0] sag_adim,
    output logic [1:0] sol_adim,
    output logic       sorgu_gecerli,
    output logic       acik,
    output logic       kilitli,
    output logic [1:0] kalan_hak
);

    localparam int TW = $clog2(KILITLEME_SURESI + 1);
    localparam int IW = $clog2(ZAMAN_ASIMI + 1);

    typedef enum logic [2:0] {BOSTA, SAG, SOL, SORGU, ACIK, CEZA} durum_t;

    durum_t      durum_q, durum_d;
    logic [2:0]  sag_adim_q, sag_adim_d;
    logic [1:0]  sol_adim_q, sol_adim_d;
    logic        sorgu_gecerli_q, sorgu_gecerli_d;
    logic        acik_q, acik_d;
    logic        kilitli_q, kilitli_d;
    logic [1:0]  kalan_hak_q, kalan_hak_d;
    logic [TW-1:0] ceza_sayac_q, ceza_sayac_d;
    logic [IW-1:0] bos_sayac_q, bos_sayac_d;

    logic tek_sag, tek_sol, hareket;

    // Simultaneous left and right pulses cancel; any pulse (even an ignored one) or onay counts as activity.
    assign tek_sag = sag_darbe & ~sol_darbe;
    assign tek_sol = sol_darbe & ~sag_darbe;
    assign hareket = sag_darbe | sol_darbe | onay;

    always_comb begin
        durum_d      = durum_q;
        sag_adim_d   = sag_adim_q;
        sol_adim_d   = sol_adim_q;
        kalan_hak_d  = kalan_hak_q;
        ceza_sayac_d = ceza_sayac_q;
        bos_sayac_d  = bos_sayac_q;

        case (durum_q)
            BOSTA, SAG, SOL: begin
                if (iptal) begin
                    durum_d     = BOSTA;
                    sag_adim_d  = 3'd0;
                    sol_adim_d  = 2'd0;
                    bos_sayac_d = '0;
                end else if (onay) begin
                    // Counts freeze; a pulse arriving with onay is dropped.
                    durum_d     = SORGU;
                    bos_sayac_d = '0;
                end else begin
                    if (durum_q == BOSTA) begin
                        if (tek_sag) begin
                            durum_d     = SAG;
                            sag_adim_d  = 3'd1;
                            bos_sayac_d = '0;
                        end
                    end else if (durum_q == SAG) begin
                        if (tek_sag) begin
                            sag_adim_d = sag_adim_q + 3'd1;   // wraps 7 -> 0
                        end else if (tek_sol) begin
                            durum_d     = SOL;
                            sol_adim_d  = 2'd1;
                            bos_sayac_d = '0;
                        end
                    end else begin
                        // Right steps are not accepted once the left phase has begun.
                        if (tek_sol) begin
                            sol_adim_d = sol_adim_q + 2'd1;   // wraps 3 -> 0
                        end
                    end

                    // Idle timeout only while staying in the same entry phase.
                    if (durum_q != BOSTA && durum_d == durum_q) begin
                        if (hareket) begin
                            bos_sayac_d = '0;
                        end else if (bos_sayac_q == IW'(ZAMAN_ASIMI - 1)) begin
                            durum_d     = BOSTA;
                            sag_adim_d  = 3'd0;
                            sol_adim_d  = 2'd0;
                            bos_sayac_d = '0;
                        end else begin
                            bos_sayac_d = bos_sayac_q + IW'(1);
                        end
                    end
                end
            end
            SORGU: begin
                if (kilit_acik) begin
                    durum_d     = ACIK;
                    kalan_hak_d = 2'(DENEME_HAKKI);
                end else if (kalan_hak_q == 2'd1) begin
                    // Counts stay visible during lockout and are cleared on exit.
                    durum_d      = CEZA;
                    kalan_hak_d  = 2'd0;
                    ceza_sayac_d = TW'(KILITLEME_SURESI);
                end else begin
                    durum_d     = BOSTA;
                    kalan_hak_d = kalan_hak_q - 2'd1;
                    sag_adim_d  = 3'd0;
                    sol_adim_d  = 2'd0;
                end
            end
            ACIK: begin
                if (iptal) begin
                    durum_d    = BOSTA;
                    sag_adim_d = 3'd0;
                    sol_adim_d = 2'd0;
                end
            end
            CEZA: begin
                // Loaded with the full length on entry, so CEZA lasts exactly that many cycles.
                if (ceza_sayac_q == TW'(1)) begin
                    durum_d      = BOSTA;
                    kalan_hak_d  = 2'(DENEME_HAKKI);
                    sag_adim_d   = 3'd0;
                    sol_adim_d   = 2'd0;
                    ceza_sayac_d = '0;
                end else begin
                    ceza_sayac_d = ceza_sayac_q - TW'(1);
                end
            end
            default: begin
                durum_d    = BOSTA;
                sag_adim_d = 3'd0;
                sol_adim_d = 2'd0;
            end
        endcase

        sorgu_gecerli_d = (durum_d == SORGU);
        acik_d          = (durum_d == ACIK);
        kilitli_d       = (durum_d == CEZA);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            durum_q         <= BOSTA;
            sag_adim_q      <= 3'd0;
            sol_adim_q      <= 2'd0;
            sorgu_gecerli_q <= 1'b0;
            acik_q          <= 1'b0;
            kilitli_q       <= 1'b0;
            kalan_hak_q     <= 2'(DENEME_HAKKI);
            ceza_sayac_q    <= '0;
            bos_sayac_q     <= '0;
        end else begin
            durum_q         <= durum_d;
            sag_adim_q      <= sag_adim_d;
            sol_adim_q      <= sol_adim_d;
            sorgu_gecerli_q <= sorgu_gecerli_d;
            acik_q          <= acik_d;
            kilitli_q       <= kilitli_d;
            kalan_hak_q     <= kalan_hak_d;
            ceza_sayac_q    <= ceza_sayac_d;
            bos_sayac_q     <= bos_sayac_d;
        end
    end

    assign sag_adim      = sag_adim_q;
    assign sol_adim      = sol_adim_q;
    assign sorgu_gecerli = sorgu_gecerli_q;
    assign acik          = acik_q;
    assign kilitli       = kilitli_q;
    assign kalan_hak     = kalan_hak_q;

endmodule

// File: tb/tb_kilit_denetleyici.sv
module tb_kilit_denetleyici;

    localparam int HAK   = 3;
    localparam int SURE  = 16;
    localparam int ASIMI = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sag_darbe = 1'b0, sol_darbe = 1'b0, onay = 1'b0, iptal = 1'b0;
    logic       kilit_acik;
    logic [2:0] sag_adim;
    logic [1:0] sol_adim;
    logic       sorgu_gecerli, acik, kilitli;
    logic [1:0] kalan_hak;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    kilit_denetleyici #(
        .DENEME_HAKKI(HAK), .KILITLEME_SURESI(SURE), .ZAMAN_ASIMI(ASIMI)
    ) dut (
        .clk(clk), .rst(rst),
        .sag_darbe(sag_darbe), .sol_darbe(sol_darbe), .onay(onay), .iptal(iptal),
        .kilit_acik(kilit_acik),
        .sag_adim(sag_adim), .sol_adim(sol_adim),
        .sorgu_gecerli(sorgu_gecerli), .acik(acik), .kilitli(kilitli),
        .kalan_hak(kalan_hak)
    );

    // Stand-in for kilit_acici with kilit_sifre=25: right step worth 5, left step worth 10.
    assign kilit_acik = ((5 * int'(sag_adim) + 10 * int'(sol_adim)) == 25);

    // Reference model: phase 0 idle, 1 right, 2 left, 3 query, 4 open, 5 lockout.
    int m_faz, m_sag, m_sol, m_hak, m_kalan_ceza, m_sessiz;

    task automatic model_reset();
        m_faz = 0; m_sag = 0; m_sol = 0; m_hak = HAK; m_kalan_ceza = 0; m_sessiz = 0;
    endtask

    task automatic model_edge(input bit a, input bit b, input bit o, input bit c);
        int eski;
        eski = m_faz;
        if (m_faz <= 2) begin
            if (c) begin
                m_faz = 0; m_sag = 0; m_sol = 0;
            end else if (o) begin
                m_faz = 3;
            end else if (a && !b && m_faz == 0) begin
                m_faz = 1; m_sag = 1;
            end else if (a && !b && m_faz == 1) begin
                m_sag = (m_sag + 1) % 8;
            end else if (b && !a && m_faz == 1) begin
                m_faz = 2; m_sol = 1;
            end else if (b && !a && m_faz == 2) begin
                m_sol = (m_sol + 1) % 4;
            end
            if (!c && !o && eski != 0 && m_faz == eski) begin
                if (a || b) m_sessiz = 0;
                else begin
                    m_sessiz++;
                    if (m_sessiz >= ASIMI) begin
                        m_faz = 0; m_sag = 0; m_sol = 0; m_sessiz = 0;
                    end
                end
            end else begin
                m_sessiz = 0;
            end
        end else if (m_faz == 3) begin
            if (5 * m_sag + 10 * m_sol == 25) begin
                m_faz = 4; m_hak = HAK;
            end else begin
                m_hak--;
                if (m_hak == 0) begin
                    m_faz = 5; m_kalan_ceza = SURE;
                end else begin
                    m_faz = 0; m_sag = 0; m_sol = 0;
                end
            end
        end else if (m_faz == 4) begin
            if (c) begin
                m_faz = 0; m_sag = 0; m_sol = 0;
            end
        end else begin
            m_kalan_ceza--;
            if (m_kalan_ceza == 0) begin
                m_faz = 0; m_sag = 0; m_sol = 0; m_hak = HAK;
            end
        end
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".sag_adim"}, int'(sag_adim), m_sag);
        chk({tag, ".sol_adim"}, int'(sol_adim), m_sol);
        chk({tag, ".sorgu"}, int'(sorgu_gecerli), int'(m_faz == 3));
        chk({tag, ".acik"}, int'(acik), int'(m_faz == 4));
        chk({tag, ".kilitli"}, int'(kilitli), int'(m_faz == 5));
        chk({tag, ".kalan_hak"}, int'(kalan_hak), m_hak);
    endtask

    // Drive one cycle of inputs, advance model at the edge, check just after it.
    task automatic step(input bit a, input bit b, input bit o, input bit c, input string tag);
        sag_darbe = a; sol_darbe = b; onay = o; iptal = c;
        @(posedge clk);
        model_edge(a, b, o, c);
        #1;
        chk_all(tag);
    endtask

    task automatic do_reset(input bit o, input string tag);
        rst = 1'b1; sag_darbe = 1'b1; sol_darbe = 1'b0; onay = o; iptal = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        chk_all(tag);
        rst = 1'b0;
    endtask

    initial begin
        int cnt;
        bit a, b, o, c;
        model_reset();
        sag_darbe = 0; sol_darbe = 0; onay = 0; iptal = 0;
        @(posedge clk); #1;
        do_reset(1'b0, "reset");
        chk("reset.kalan_hak_const", int'(kalan_hak), 3);

        // 1: open with 1 right, 2 left, then relock.
        step(1, 0, 0, 0, "t1.sag");
        step(0, 1, 0, 0, "t1.sol1");
        step(0, 1, 0, 0, "t1.sol2");
        step(0, 0, 1, 0, "t1.onay");
        chk("t1.sorgu_const", int'(sorgu_gecerli), 1);
        step(0, 0, 0, 0, "t1.acik");
        chk("t1.acik_const", int'(acik), 1);
        step(1, 1, 1, 0, "t1.ignored");
        step(0, 0, 0, 1, "t1.iptal");
        chk("t1.relocked", int'(acik), 0);

        // 2: right wrap, left wrap, pulse dropped with onay.
        for (int i = 0; i < 9; i++) step(1, 0, 0, 0, "t2.sag");
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, "t2.sol");
        step(0, 1, 1, 0, "t2.sol_onay");
        step(0, 0, 0, 0, "t2.sorgu_sonu");

        // 3: three failures (2 right = 10) then lockout of exactly SURE cycles.
        do_reset(1'b0, "t3.reset");
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 0, 0, "t3.sag1");
            step(1, 0, 0, 0, "t3.sag2");
            step(0, 0, 1, 0, "t3.onay");
            if (k < 2) step(0, 0, 0, 0, "t3.fail");
        end
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (i < 15) step(1, 0, i[0], 0, "t3.ceza");
            else step(0, 0, 0, 0, "t3.ceza");
            if (kilitli) cnt++;
        end
        chk("t3.ceza_cycles", cnt, SURE);

        // 4: idle timeout and its boundary.
        step(1, 0, 0, 0, "t4.sag");
        for (int i = 0; i < ASIMI; i++) step(0, 0, 0, 0, "t4.quiet");
        chk("t4.timed_out", int'(sag_adim), 0);
        step(1, 0, 0, 0, "t4.sag_b");
        for (int i = 0; i < ASIMI - 1; i++) step(0, 0, 0, 0, "t4.quiet_b");
        step(1, 0, 0, 0, "t4.sag_c");
        chk("t4.still_sag", int'(sag_adim), 2);

        // 5: simultaneous pulses, right in left phase, onay from idle.
        step(1, 1, 0, 0, "t5.both");
        step(0, 1, 0, 0, "t5.sol");
        step(1, 0, 0, 0, "t5.sag_in_sol");
        do_reset(1'b0, "t5.reset");
        step(0, 0, 1, 0, "t5.onay_bosta");
        step(0, 0, 0, 0, "t5.fail");
        chk("t5.kalan_hak_const", int'(kalan_hak), 2);

        // 6: reset mid-lockout, with onay held high during reset.
        step(0, 0, 1, 0, "t6.onay2");
        step(0, 0, 0, 0, "t6.fail2");
        step(0, 0, 1, 0, "t6.onay3");
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, "t6.ceza");
        do_reset(1'b1, "t6.reset");
        chk("t6.kilitli_const", int'(kilitli), 0);
        chk("t6.kalan_hak_const", int'(kalan_hak), 3);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            a = ($urandom_range(0, 99) < 35);
            b = ($urandom_range(0, 99) < 30);
            o = ($urandom_range(0, 99) < 7);
            c = ($urandom_range(0, 99) < 3);
            step(a, b, o, c, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
